// File: rtl/obi_2_cont.sv
// obi_2_cont: bridge from the Ibex OBI data port to the UART transaction controller.
//    One request at a time; full-word controller transfers, partial stores done as
//    read-modify-write (read word, merge enabled bytes, write word back).
// Latency: gnt->rvalid 4 clocks minimum for a single transfer, plus one read round
//    trip for partial stores; zero-enable stores answer in the cycle after grant.
// Backpressure: data_gnt_o only in IDLE; the controller paces each transfer through
//    the start/complete level handshake.
//
// Ports:
//    clk_i, rst_i (async, active-high)
//    data_*    : OBI data port (req/gnt/we/be/addr/wdata in, rvalid/err/rdata out)
//    cont_*    : controller side (address/start/we/data out, complete/read_data in)
//
// Optional feature: define OBI_2_CONT_TIMEOUT_EN to enable a per-transaction
//    watchdog of TIMEOUT_CYCLES clocks that ends a stuck transfer with an error
//    response (err=1, rdata=32'hDEAD_BEEF). Without it data_err_o is tied to 0.

module obi_2_cont #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   output logic [31:0] data_rdata_o,
   output logic [12:0] cont_address_o,
   output logic        cont_start_o,
   output logic        cont_we_o,
   output logic [31:0] cont_data_o,
   input  logic        cont_complete_i,
   input  logic [31:0] cont_read_data_i
);

   typedef enum logic [1:0] {IDLE, XFER, GAP, RESP} state_t;

   state_t      state, state_nxt;
   logic        we_q, we_nxt;
   logic [3:0]  be_q, be_nxt;
   logic [31:0] wdata_q, wdata_nxt;
   logic [31:0] rd_word_q, rd_word_nxt;
   // Set while a partial store is in its read phase; the write phase follows GAP.
   logic        rmw_q, rmw_nxt;

   logic [12:0] address_nxt;
   logic        start_nxt, cont_we_nxt, rvalid_nxt;
   logic [31:0] cont_data_nxt, rdata_nxt;
   logic [31:0] merged;

   // Only the word index inside the controller's 13-bit space matters.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{data_addr_i[31:15], data_addr_i[1:0]};

`ifdef OBI_2_CONT_TIMEOUT_EN
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
   logic [15:0] cnt_q, cnt_nxt;
   logic        tmo_q, tmo_nxt;
   logic        err_nxt;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES == 0);
   assign data_err_o = 1'b0;
`endif

   assign data_gnt_o = data_req_i && (state == IDLE);

   always_comb begin
      merged = rd_word_q;
      for (int k = 0; k < 4; k++) begin
         if (be_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
      end
   end

   always_comb begin
      state_nxt     = state;
      we_nxt        = we_q;
      be_nxt        = be_q;
      wdata_nxt     = wdata_q;
      rd_word_nxt   = rd_word_q;
      rmw_nxt       = rmw_q;
      address_nxt   = cont_address_o;
      start_nxt     = cont_start_o;
      cont_we_nxt   = cont_we_o;
      cont_data_nxt = cont_data_o;
      rvalid_nxt    = 1'b0;
      rdata_nxt     = data_rdata_o;
`ifdef OBI_2_CONT_TIMEOUT_EN
      cnt_nxt       = cnt_q;
      tmo_nxt       = tmo_q;
      err_nxt       = data_err_o;
`endif

      unique case (state)
         IDLE: begin
            if (data_req_i) begin
               address_nxt = data_addr_i[14:2];
               we_nxt      = data_we_i;
               be_nxt      = data_be_i;
               wdata_nxt   = data_wdata_i;
`ifdef OBI_2_CONT_TIMEOUT_EN
               cnt_nxt     = 16'd0;
               tmo_nxt     = 1'b0;
               err_nxt     = 1'b0;
`endif
               if (data_we_i && data_be_i == 4'h0) begin
                  // Nothing to store: acknowledge without touching the controller.
                  rvalid_nxt = 1'b1;
                  rdata_nxt  = 32'h0;
                  state_nxt  = RESP;
               end else begin
                  start_nxt = 1'b1;
                  state_nxt = XFER;
                  if (data_we_i && data_be_i == 4'hF) begin
                     cont_we_nxt   = 1'b1;
                     cont_data_nxt = data_wdata_i;
                     rmw_nxt       = 1'b0;
                  end else begin
                     // Loads and the read half of a partial store.
                     cont_we_nxt = 1'b0;
                     rmw_nxt     = data_we_i;
                  end
               end
            end
         end

         XFER: begin
            if (cont_complete_i) begin
               rd_word_nxt = cont_read_data_i;
               start_nxt   = 1'b0;
               state_nxt   = GAP;
            end
`ifdef OBI_2_CONT_TIMEOUT_EN
            else if (cnt_q + 16'd1 == TMO_LIM) begin
               start_nxt = 1'b0;
               tmo_nxt   = 1'b1;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt_q + 16'd1;
            end
`endif
         end

         GAP: begin
            // Wait for complete to fall so the next start edge is clean.
            if (!cont_complete_i) begin
`ifdef OBI_2_CONT_TIMEOUT_EN
               if (tmo_q) begin
                  rvalid_nxt = 1'b1;
                  err_nxt    = 1'b1;
                  rdata_nxt  = 32'hDEAD_BEEF;
                  rmw_nxt    = 1'b0;
                  tmo_nxt    = 1'b0;
                  state_nxt  = RESP;
               end else
`endif
               if (rmw_q) begin
                  cont_data_nxt = merged;
                  cont_we_nxt   = 1'b1;
                  start_nxt     = 1'b1;
                  rmw_nxt       = 1'b0;
                  state_nxt     = XFER;
`ifdef OBI_2_CONT_TIMEOUT_EN
                  cnt_nxt       = 16'd0;
`endif
               end else begin
                  rvalid_nxt = 1'b1;
                  rdata_nxt  = we_q ? 32'h0 : rd_word_q;
                  state_nxt  = RESP;
               end
            end
         end

         RESP: begin
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= IDLE;
         we_q           <= 1'b0;
         be_q           <= 4'h0;
         wdata_q        <= 32'h0;
         rd_word_q      <= 32'h0;
         rmw_q          <= 1'b0;
         cont_address_o <= 13'h0;
         cont_start_o   <= 1'b0;
         cont_we_o      <= 1'b0;
         cont_data_o    <= 32'h0;
         data_rvalid_o  <= 1'b0;
         data_rdata_o   <= 32'h0;
`ifdef OBI_2_CONT_TIMEOUT_EN
         cnt_q          <= 16'h0;
         tmo_q          <= 1'b0;
         data_err_o     <= 1'b0;
`endif
      end else begin
         state          <= state_nxt;
         we_q           <= we_nxt;
         be_q           <= be_nxt;
         wdata_q        <= wdata_nxt;
         rd_word_q      <= rd_word_nxt;
         rmw_q          <= rmw_nxt;
         cont_address_o <= address_nxt;
         cont_start_o   <= start_nxt;
         cont_we_o      <= cont_we_nxt;
         cont_data_o    <= cont_data_nxt;
         data_rvalid_o  <= rvalid_nxt;
         data_rdata_o   <= rdata_nxt;
`ifdef OBI_2_CONT_TIMEOUT_EN
         cnt_q          <= cnt_nxt;
         tmo_q          <= tmo_nxt;
         data_err_o     <= err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_obi_2_cont.sv
// tb_obi_2_cont: directed bench for obi_2_cont with a small behavioural controller
//    that raises complete one cycle after start and drops it once start falls.
module tb_obi_2_cont;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        data_req_i, data_gnt_o, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic [12:0] cont_address_o;
   logic        cont_start_o, cont_we_o;
   logic [31:0] cont_data_o;
   logic        cont_complete_i;
   logic [31:0] cont_read_data_i;

   always #5 clk = ~clk;

   obi_2_cont #(.TIMEOUT_CYCLES(16)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .data_req_i       (data_req_i),
      .data_gnt_o       (data_gnt_o),
      .data_we_i        (data_we_i),
      .data_be_i        (data_be_i),
      .data_addr_i      (data_addr_i),
      .data_wdata_i     (data_wdata_i),
      .data_rvalid_o    (data_rvalid_o),
      .data_err_o       (data_err_o),
      .data_rdata_o     (data_rdata_o),
      .cont_address_o   (cont_address_o),
      .cont_start_o     (cont_start_o),
      .cont_we_o        (cont_we_o),
      .cont_data_o      (cont_data_o),
      .cont_complete_i  (cont_complete_i),
      .cont_read_data_i (cont_read_data_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Controller model: one memory word, edge log, start high/low run lengths.
   logic        ctl_en     = 1'b1;
   logic [31:0] mem_word   = 32'h0;
   logic        start_prev = 1'b0;
   int          edges = 0, hi_cnt = 0, last_hi = 0, lo_cnt = 0, last_lo = 0;
   logic        edge_we[$];
   logic [31:0] edge_data[$];
   logic [12:0] edge_addr[$];

   initial begin
      cont_complete_i  = 1'b0;
      cont_read_data_i = 32'h0;
   end

   always @(posedge clk) begin
      #1;
      if (cont_start_o && !start_prev) begin
         edges++;
         edge_we.push_back(cont_we_o);
         edge_data.push_back(cont_data_o);
         edge_addr.push_back(cont_address_o);
         last_lo = lo_cnt;
         hi_cnt  = 0;
         if (cont_we_o) mem_word = cont_data_o;
      end
      if (cont_start_o) hi_cnt++;
      else begin
         if (start_prev) begin
            last_hi = hi_cnt;
            lo_cnt  = 0;
         end
         lo_cnt++;
      end
      cont_complete_i  = ctl_en && cont_start_o && start_prev;
      cont_read_data_i = cont_complete_i ? mem_word : 32'h0;
      start_prev       = cont_start_o;
   end

   task automatic clear_log();
      edges = 0;
      edge_we.delete();
      edge_data.delete();
      edge_addr.delete();
   endtask

   // Issue one request, wait (bounded) for rvalid; lat counts cycles after the grant cycle.
   task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic err,
                         output int lat);
      @(negedge clk);
      data_req_i = 1'b1; data_we_i = we; data_be_i = be;
      data_addr_i = addr; data_wdata_i = wd;
      #1;
      check("gnt", 32'(data_gnt_o), 32'd1);
      @(negedge clk);
      data_req_i = 1'b0;
      lat = 1;
      while (!data_rvalid_o && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!data_rvalid_o) check("rvalid_timeout", 32'(data_rvalid_o), 32'd1);
      rd  = data_rdata_o;
      err = data_err_o;
      // A request during the response cycle must not be granted.
      data_req_i = 1'b1; data_we_i = 1'b0;
      #1;
      check("gnt_in_resp", 32'(data_gnt_o), 32'd0);
      data_req_i = 1'b0;
      @(negedge clk);
      check("rvalid_single", 32'(data_rvalid_o), 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   logic [31:0] rd;
   logic        err;
   int          lat;

   initial begin
      rst_i = 1'b1;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
      data_addr_i = 32'h0; data_wdata_i = 32'h0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("rst_start",  32'(cont_start_o),   32'd0);
      check("rst_rvalid", 32'(data_rvalid_o),  32'd0);
      check("rst_err",    32'(data_err_o),     32'd0);
      check("rst_rdata",  data_rdata_o,        32'h0);
      check("rst_addr",   32'(cont_address_o), 32'h0);
      check("rst_cwe",    32'(cont_we_o),      32'd0);
      check("rst_cdata",  cont_data_o,         32'h0);
      check("rst_gnt",    32'(data_gnt_o),     32'd0);

      // Plain read.
      clear_log(); mem_word = 32'h1234_5678;
      do_req(1'b0, 4'hF, 32'h0000_0104, 32'h0, rd, err, lat);
      check("rd_addr",  32'(edge_addr[0]), 32'h041);
      check("rd_we",    32'(edge_we[0]),   32'd0);
      check("rd_edges", 32'(edges),        32'd1);
      check("rd_data",  rd,                32'h1234_5678);
      check("rd_err",   32'(err),          32'd0);
      check("rd_lat",   32'(lat),          32'd4);

      // Full write.
      clear_log();
      do_req(1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, rd, err, lat);
      check("wr_edges", 32'(edges),        32'd1);
      check("wr_we",    32'(edge_we[0]),   32'd1);
      check("wr_data",  edge_data[0],      32'hCAFE_F00D);
      check("wr_addr",  32'(edge_addr[0]), 32'h004);
      check("wr_rdata", rd,                32'h0);
      check("wr_lat",   32'(lat),          32'd4);

      // Partial write: read 0x1122_3344, replace byte 1.
      clear_log(); mem_word = 32'h1122_3344;
      do_req(1'b1, 4'b0010, 32'h0000_0020, 32'h0000_AB00, rd, err, lat);
      check("rmw_edges", 32'(edges),      32'd2);
      check("rmw_we0",   32'(edge_we[0]), 32'd0);
      check("rmw_we1",   32'(edge_we[1]), 32'd1);
      check("rmw_data",  edge_data[1],    32'h1122_AB44);
      check("rmw_gap",   32'(last_lo >= 1), 32'd1);
      check("rmw_lat",   32'(lat),        32'd7);
      check("rmw_mem",   mem_word,        32'h1122_AB44);

      // Upper and low address bits ignored; reads back the merged word.
      clear_log();
      do_req(1'b0, 4'hF, 32'hFFFF_8007, 32'h0, rd, err, lat);
      check("ign_addr", 32'(edge_addr[0]), 32'h001);
      check("ign_data", rd,                32'h1122_AB44);

      // Zero-enable write: no controller activity.
      clear_log();
      do_req(1'b1, 4'h0, 32'h0000_0030, 32'hFFFF_FFFF, rd, err, lat);
      check("be0_edges", 32'(edges), 32'd0);
      check("be0_lat",   32'(lat),   32'd1);
      check("be0_rdata", rd,         32'h0);
      check("be0_err",   32'(err),   32'd0);

      // Reset in the middle of a stalled transfer.
      clear_log(); ctl_en = 1'b0;
      @(negedge clk);
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0000_0200;
      @(negedge clk);
      data_req_i = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_start", 32'(cont_start_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("arst_start",  32'(cont_start_o),   32'd0);
      check("arst_addr",   32'(cont_address_o), 32'h0);
      check("arst_rvalid", 32'(data_rvalid_o),  32'd0);
      @(negedge clk);
      rst_i = 1'b0; ctl_en = 1'b1;
      lat = 0;
      repeat (4) begin
         @(negedge clk);
         if (data_rvalid_o || cont_start_o) lat++;
      end
      check("arst_quiet", 32'(lat), 32'd0);
      clear_log(); mem_word = 32'h55AA_33CC;
      do_req(1'b0, 4'hF, 32'h0000_0008, 32'h0, rd, err, lat);
      check("post_rst_data",  rd,                32'h55AA_33CC);
      check("post_rst_addr",  32'(edge_addr[0]), 32'h002);
      check("post_rst_edges", 32'(edges),        32'd1);

`ifdef OBI_2_CONT_TIMEOUT_EN
      // Controller never completes: watchdog of 16 XFER cycles.
      clear_log(); ctl_en = 1'b0;
      do_req(1'b0, 4'hF, 32'h0000_0040, 32'h0, rd, err, lat);
      check("tmo_hi",    32'(last_hi), 32'd16);
      check("tmo_err",   32'(err),     32'd1);
      check("tmo_rdata", rd,           32'hDEAD_BEEF);
      check("tmo_lat",   32'(lat),     32'd18);
      clear_log();
      do_req(1'b1, 4'b0001, 32'h0000_0044, 32'h0000_0077, rd, err, lat);
      check("tmo_rmw_edges", 32'(edges), 32'd1);
      check("tmo_rmw_err",   32'(err),   32'd1);
      ctl_en = 1'b1;
      clear_log(); mem_word = 32'h0BAD_F00D;
      do_req(1'b0, 4'hF, 32'h0000_0048, 32'h0, rd, err, lat);
      check("tmo_recover_err",  32'(err), 32'd0);
      check("tmo_recover_data", rd,       32'h0BAD_F00D);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
